// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words while the bus is free and
// presents the head entry to decode. Optional counters under FETCH_QUEUE_STATS_EN.
module fetch_queue #(
  parameter int unsigned         DATA_WIDTH      = 32,
  parameter int unsigned         ADDR_WIDTH      = 32,
  parameter int unsigned         DEPTH           = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = 32'h0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = 32'h0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         bus_grant,
  output logic [ADDR_WIDTH-1:0]        fetch_address,
  output logic                         fetch_read,
  input  logic [DATA_WIDTH-1:0]        fetch_data,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_address,
  input  logic                         consume,
  output logic [DATA_WIDTH-1:0]        instruction,
  output logic [ADDR_WIDTH-1:0]        instruction_address,
  output logic                         instruction_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                  stat_fetches,
  output logic [31:0]                  stat_flushed,
  output logic [31:0]                  stat_starved
`endif
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic                  full, empty, take;

  always_comb begin
    full        = (level_q == FULL_LEVEL);
    empty       = (level_q == '0);
    fetch_read  = bus_grant & ~full & ~redirect & ~reset;
    take        = consume & ~empty & ~redirect;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    fetch_ptr_d = fetch_ptr_q;
    if (redirect) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      fetch_ptr_d = {redirect_address[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      if (fetch_read) begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fetch_ptr_d = fetch_ptr_q + ADDR_WIDTH'(4);
      end
      if (take) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({fetch_read, take})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      fetch_ptr_q <= RESET_ADDRESS;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      fetch_ptr_q <= fetch_ptr_d;
    end
  end

  // Storage needs no reset: level_q gates every read of it.
  always_ff @(posedge clock) begin
    if (fetch_read) begin
      data_q[wr_ptr_q] <= fetch_data;
      addr_q[wr_ptr_q] <= fetch_ptr_q;
    end
  end

  always_comb begin
    fetch_address       = fetch_ptr_q;
    level               = level_q;
    instruction_valid   = ~empty;
    instruction         = empty ? NOP_INSTRUCTION : data_q[rd_ptr_q];
    instruction_address = empty ? '0 : addr_q[rd_ptr_q];
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetches_q, stat_fetches_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic [31:0] stat_starved_q, stat_starved_d;
  logic [32:0] flushed_sum;

  always_comb begin
    stat_fetches_d = stat_fetches_q;
    stat_flushed_d = stat_flushed_q;
    stat_starved_d = stat_starved_q;
    flushed_sum    = {1'b0, stat_flushed_q} + 33'(level_q);
    if (fetch_read && stat_fetches_q != '1) stat_fetches_d = stat_fetches_q + 32'd1;
    if (consume && empty && stat_starved_q != '1) stat_starved_d = stat_starved_q + 32'd1;
    if (redirect) stat_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_fetches_q <= '0;
      stat_flushed_q <= '0;
      stat_starved_q <= '0;
    end else begin
      stat_fetches_q <= stat_fetches_d;
      stat_flushed_q <= stat_flushed_d;
      stat_starved_q <= stat_starved_d;
    end
  end

  assign stat_fetches = stat_fetches_q;
  assign stat_flushed = stat_flushed_q;
  assign stat_starved = stat_starved_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps plus random traffic against
// a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_grant = 1'b0;
  logic [31:0] fetch_address;
  logic        fetch_read;
  logic [31:0] fetch_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_address = '0;
  logic        consume = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instruction_address;
  logic        instruction_valid;
  logic [2:0]  level;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetches, stat_flushed, stat_starved;
`endif

  fetch_queue #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
    .RESET_ADDRESS(32'h0), .NOP_INSTRUCTION(NOP)
  ) dut (
    .clock(clock), .reset(reset), .bus_grant(bus_grant),
    .fetch_address(fetch_address), .fetch_read(fetch_read), .fetch_data(fetch_data),
    .redirect(redirect), .redirect_address(redirect_address), .consume(consume),
    .instruction(instruction), .instruction_address(instruction_address),
    .instruction_valid(instruction_valid), .level(level)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_fetches(stat_fetches), .stat_flushed(stat_flushed), .stat_starved(stat_starved)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; logic [31:0] addr; } entry_t;
  entry_t      q[$];
  logic [31:0] m_fptr = 32'h0;
  int          m_fetches = 0, m_flushed = 0, m_starved = 0;
  int          checks = 0, failures = 0;
  bit          rnd_data = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head();
    check("level", 64'(level), 64'(q.size()));
    check("valid", 64'(instruction_valid), 64'(q.size() != 0));
    check("instr", 64'(instruction), 64'(q.size() != 0 ? q[0].data : NOP));
    check("iaddr", 64'(instruction_address), 64'(q.size() != 0 ? q[0].addr : 32'h0));
  endtask

  // One clock: drive inputs, check fetch side before the edge, update model, check head after.
  task automatic step(input bit bg, input bit cons, input bit redir, input logic [31:0] raddr);
    bit exp_fetch;
    bus_grant = bg; consume = cons; redirect = redir; redirect_address = raddr;
    fetch_data = rnd_data ? $urandom : 32'h1000_0000 + m_fptr;
    exp_fetch = bg && !redir && q.size() < DEPTH;
    #1;
    check("fetch_read", 64'(fetch_read), 64'(exp_fetch));
    check("fetch_addr", 64'(fetch_address), 64'(m_fptr));
    @(posedge clock);
    if (cons && q.size() == 0) m_starved++;
    if (redir) begin
      m_flushed += q.size();
      q.delete();
      m_fptr = raddr & 32'hFFFF_FFFC;
    end else begin
      if (cons && q.size() > 0) void'(q.pop_front());
      if (exp_fetch) begin
        q.push_back('{data: fetch_data, addr: m_fptr});
        m_fetches++;
        m_fptr += 32'd4;
      end
    end
    #1;
    check_head();
  endtask

  task automatic reach_level(input int n);
    for (int i = 0; i < 20 && q.size() != n; i++)
      step(q.size() < n, q.size() > n, 1'b0, 32'h0);
    check("reach_level", 64'(q.size()), 64'(n));
  endtask

  initial begin
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] flushed_before;
`endif
    bus_grant = 1'b1;
    #12;
    check("rst_fetch_read", 64'(fetch_read), 64'(0));
    check("rst_fetch_addr", 64'(fetch_address), 64'(32'h0));
    check_head();
    reset = 1'b0;

    // Fill: addresses 0,4,8,C then full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_level", 64'(level), 64'(4));
    check("full_head", 64'(instruction), 64'(32'h1000_0000));

    // Drain while refilling.
    for (int i = 0; i < 6; i++) begin
      check("drain_addr", 64'(instruction_address), 64'(32'(i * 4)));
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Redirect at level 3 with unaligned target.
    reach_level(3);
`ifdef FETCH_QUEUE_STATS_EN
    flushed_before = stat_flushed;
`endif
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("redir_level", 64'(level), 64'(0));
    check("redir_instr", 64'(instruction), 64'(NOP));
    check("redir_faddr", 64'(fetch_address), 64'(32'h200));
`ifdef FETCH_QUEUE_STATS_EN
    check("stat_flush3", 64'(stat_flushed - flushed_before), 64'(3));
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_head", 64'(instruction), 64'(32'h1000_0200));

    // Starve: grant toggles with consume every cycle.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b1, 1'b0, 32'h0);

    // Fetch pointer wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_faddr", 64'(fetch_address), 64'(32'h0));
    check("wrap_head_addr", 64'(instruction_address), 64'(32'hFFFF_FFFC));

    // Async reset mid-stream at level 2.
    reach_level(2);
    bus_grant = 1'b1;
    #2 reset = 1'b1;
    #1;
    q.delete(); m_fptr = 32'h0;
    m_fetches = 0; m_flushed = 0; m_starved = 0;
    check("arst_fetch_read", 64'(fetch_read), 64'(0));
    check("arst_faddr", 64'(fetch_address), 64'(32'h0));
    check_head();
    @(posedge clock);
    #1 reset = 1'b0;
    check_head();

    // Random traffic.
    rnd_data = 1'b1;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom);

`ifdef FETCH_QUEUE_STATS_EN
    check("stat_fetches", 64'(stat_fetches), 64'(m_fetches));
    check("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
    check("stat_starved", 64'(stat_starved), 64'(m_starved));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction prefetch buffer between the bus interface and memorystage1 in the next-generation pipeline.
- Fetches sequential 32-bit words whenever the bus is free (no memory-access cycle), so operand accesses no longer cost fetch bubbles.
- Supplies decode with the head instruction and its address; emits a NOP word when empty.
- Flushes and re-targets on a control-flow redirect.

Parameters:
DATA_WIDTH, 32, instruction word width.
ADDR_WIDTH, 32, byte-address width of fetch pointer.
DEPTH, 4, queue entries; power of two, >= 2.
RESET_ADDRESS, 32'h0, fetch pointer value after reset.
NOP_INSTRUCTION, 32'h0, word presented when queue is empty.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high
bus_grant  input  1  bus free for an instruction fetch this cycle
fetch_address  output  ADDR_WIDTH  byte address of the next sequential fetch
fetch_read  output  1  fetch performed this cycle
fetch_data  input  DATA_WIDTH  word returned in the same cycle as fetch_read
redirect  input  1  flush queue and restart fetching at redirect_address
redirect_address  input  ADDR_WIDTH  new fetch target; bits [1:0] ignored, forced 0
consume  input  1  decode takes the head entry this cycle
instruction  output  DATA_WIDTH  head word, or NOP_INSTRUCTION when empty
instruction_address  output  ADDR_WIDTH  address of head word; 0 when empty
instruction_valid  output  1  queue non-empty
level  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, any time, including mid-fetch):
  - read/write pointers, level = 0; fetch pointer = RESET_ADDRESS.
  - instruction = NOP_INSTRUCTION, instruction_valid = 0, instruction_address = 0, fetch_read = 0.
- fetch_read = bus_grant & (level != DEPTH) & ~redirect & ~reset. This is combinational; fetch_address is the registered fetch pointer.
- On an edge with fetch_read = 1:
  - store {fetch_data, fetch_address} at the write pointer.
  - fetch pointer += 4, wrapping modulo 2^ADDR_WIDTH (e.g. ...FFFC -> 0).
- Entry latency: a fetched word appears at the head no earlier than the next cycle. There is no fall-through bypass.
- consume when instruction_valid = 0 is ignored. level never underflows.
- fetch_read and consume in the same cycle: level unchanged; both pointers advance.
- Full (level = DEPTH): fetch_read held 0 regardless of bus_grant. consume in that cycle frees one entry for the following cycle.
- Pointers wrap modulo DEPTH. level is the authoritative full/empty indicator.
- redirect, highest priority:
  - next edge: level = 0, both pointers 0, fetch pointer = {redirect_address[ADDR_WIDTH-1:2], 2'b00}.
  - consume and fetch in the redirect cycle are discarded.
  - the first fetch at the new target can occur the cycle after redirect.
- redirect together with full or empty: same result, queue empty afterwards.
- Outputs instruction, instruction_address and instruction_valid are driven from registered state only (no combinational path from inputs).

Optional Feature:
FETCH_QUEUE_STATS_EN
- Defined: adds outputs stat_fetches (32), stat_flushed (32) and stat_starved (32):
  - stat_fetches: count of fetch_read cycles.
  - stat_flushed: total valid entries discarded by redirects.
  - stat_starved: cycles with consume = 1 while empty.
  - All counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset released, bus_grant = 1, fetch_data = 32'h1000_0000 + address, consume = 0 -> fetch addresses 0, 4, 8, C on four cycles, then fetch_read = 0; level = 4; head = 32'h1000_0000 at address 0.
- Full queue, consume = 1 for 6 cycles, bus_grant = 1 -> head addresses 0, 4, 8, C, 10, 14 in order; level stays at 4 or 3; no word skipped or duplicated.
- level = 3, redirect = 1 with redirect_address = 32'h0000_0203 -> next cycle level = 0, instruction = NOP, fetch_address = 32'h0000_0200; one cycle later head = word from 32'h200.
- bus_grant toggling 1,0,1,0 with consume = 1 every cycle -> instruction_valid alternates; NOP_INSTRUCTION presented when empty; level never underflows.
- Fetch pointer 32'hFFFF_FFFC, one fetch -> next fetch_address = 32'h0.
- Assert reset mid-stream with level = 2 -> outputs immediately NOP / valid 0 / level 0, fetch_address = RESET_ADDRESS; with FETCH_QUEUE_STATS_EN, redirect at level = 3 increments stat_flushed by 3.
